// File: rtl/tlb_walk_ctrl_pkg.sv
// Shared types and constants for the TLB walk sequencer.
package tlb_walk_ctrl_pkg;

    localparam int unsigned VPN_W         = 20;
    localparam int unsigned PTE_W         = 24;
    localparam int unsigned PTE_VALID_BIT = 0;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned ADDR_W        = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StResp,
        StWalkReq,
        StWalkWait,
        StRefill,
        StDone
    } state_e;

    typedef enum logic {
        SideIf  = 1'b0,
        SideMem = 1'b1
    } side_e;

    // Flat page table: one 32-bit word per VPN; the sum wraps at 32 bits.
    function automatic logic [ADDR_W-1:0] pte_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [VPN_W-1:0]  vpn);
        return base + {{(ADDR_W - VPN_W - 2){1'b0}}, vpn, 2'b00};
    endfunction

endpackage

// File: rtl/tlb_rr_arb2.sv
// Two-way round-robin arbiter between IF and MEM requesters.
module tlb_rr_arb2
    import tlb_walk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic en,
    input  logic req_if,
    input  logic req_mem,
    output logic gnt_if,
    output logic gnt_mem
);

    side_e rr_q;

    always_comb begin
        gnt_if  = 1'b0;
        gnt_mem = 1'b0;
        if (en) begin
            if (req_if && req_mem) begin
                gnt_if  = (rr_q == SideIf);
                gnt_mem = (rr_q == SideMem);
            end else begin
                gnt_if  = req_if;
                gnt_mem = req_mem;
            end
        end
    end

    // Favour the side that was not just served.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr_q <= SideIf;
        end else if (gnt_if) begin
            rr_q <= SideMem;
        end else if (gnt_mem) begin
            rr_q <= SideIf;
        end
    end

endmodule

// File: rtl/tlb_walk_ctrl.sv
// Shared-TLB sequencer: arbitrates IF/MEM lookups, walks a flat page table on miss,
// refills the TLB and services CP0 indexed writes between transactions.
module tlb_walk_ctrl
    import tlb_walk_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              i_req,
    input  logic [VPN_W-1:0]  i_vpn,
    output logic              i_ack,
    output logic [PTE_W-1:0]  i_pte,
    output logic              i_fault,
    input  logic              d_req,
    input  logic [VPN_W-1:0]  d_vpn,
    output logic              d_ack,
    output logic [PTE_W-1:0]  d_pte,
    output logic              d_fault,
    input  logic              cp0_tlbwi,
    input  logic [IDX_W-1:0]  cp0_index,
    input  logic [VPN_W-1:0]  cp0_vpn,
    input  logic [PTE_W-1:0]  cp0_pte,
    output logic              cp0_busy,
    input  logic [ADDR_W-1:0] ptbr,
    output logic [VPN_W-1:0]  tlb_vpn,
    output logic [PTE_W-1:0]  tlb_pte_in,
    output logic              tlb_wi,
    output logic              tlb_wr,
    output logic [IDX_W-1:0]  tlb_index,
    input  logic              tlb_hit,
    input  logic [PTE_W-1:0]  tlb_pte,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_e             state_q, state_d;
    side_e              side_q;
    logic [VPN_W-1:0]   vpn_q;
    logic [PTE_W-1:0]   pte_q;
    logic               fault_q;
    logic               ack_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               timeout_hit;
    logic               cp0_pend_q;
    logic [IDX_W-1:0]   cp0_idx_q;
    logic [VPN_W-1:0]   cp0_vpn_q;
    logic [PTE_W-1:0]   cp0_pte_q;
    logic               arb_en;
    logic               gnt_if, gnt_mem;
    logic [PTE_W-1:0]   rd_pte;
    logic               unused_rdata;

    assign rd_pte       = mem_rdata[PTE_W-1:0];
    assign unused_rdata = ^mem_rdata[31:PTE_W];
    assign cnt_nxt      = cnt_q + CNT_W'(1);
    assign timeout_hit  = (cnt_nxt == CNT_W'(TIMEOUT));

    // No grant in the ack cycle: the requester still holds req until it sees ack.
    assign arb_en = (state_q == StIdle) && !cp0_pend_q && !ack_q;

    tlb_rr_arb2 u_arb (
        .clk     (clk),
        .clrn    (clrn),
        .en      (arb_en),
        .req_if  (i_req),
        .req_mem (d_req),
        .gnt_if  (gnt_if),
        .gnt_mem (gnt_mem)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (gnt_if || gnt_mem) state_d = StLookup;
            StLookup:   state_d = tlb_hit ? StResp : StWalkReq;
            StResp:     state_d = StIdle;
            StWalkReq:  state_d = StWalkWait;
            StWalkWait: begin
                if (mem_ack) begin
                    state_d = rd_pte[PTE_VALID_BIT] ? StRefill : StDone;
                end else if (timeout_hit) begin
                    state_d = StDone;
                end
            end
            StRefill:   state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            side_q     <= SideIf;
            vpn_q      <= '0;
            pte_q      <= '0;
            fault_q    <= 1'b0;
            ack_q      <= 1'b0;
            cnt_q      <= '0;
            cp0_pend_q <= 1'b0;
            cp0_idx_q  <= '0;
            cp0_vpn_q  <= '0;
            cp0_pte_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            if (cp0_tlbwi && !cp0_pend_q) begin
                cp0_pend_q <= 1'b1;
                cp0_idx_q  <= cp0_index;
                cp0_vpn_q  <= cp0_vpn;
                cp0_pte_q  <= cp0_pte;
            end else if (state_q == StIdle && cp0_pend_q) begin
                cp0_pend_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (gnt_if) begin
                        side_q <= SideIf;
                        vpn_q  <= i_vpn;
                    end else if (gnt_mem) begin
                        side_q <= SideMem;
                        vpn_q  <= d_vpn;
                    end
                end
                StResp: begin
                    pte_q   <= tlb_pte;
                    fault_q <= ~tlb_pte[PTE_VALID_BIT];
                    ack_q   <= 1'b1;
                end
                StWalkReq: cnt_q <= '0;
                StWalkWait: begin
                    cnt_q <= cnt_nxt;
                    if (mem_ack) begin
                        pte_q   <= rd_pte;
                        fault_q <= ~rd_pte[PTE_VALID_BIT];
                    end else if (timeout_hit) begin
                        pte_q   <= '0;
                        fault_q <= 1'b1;
                    end
                end
                StDone:  ack_q <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        tlb_vpn    = '0;
        tlb_pte_in = '0;
        tlb_wi     = 1'b0;
        tlb_wr     = 1'b0;
        tlb_index  = '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        unique case (state_q)
            StIdle: begin
                if (cp0_pend_q) begin
                    tlb_wi     = 1'b1;
                    tlb_index  = cp0_idx_q;
                    tlb_vpn    = cp0_vpn_q;
                    tlb_pte_in = cp0_pte_q;
                end
            end
            StLookup: tlb_vpn = vpn_q;
            StWalkReq, StWalkWait: begin
                mem_req  = 1'b1;
                mem_addr = pte_addr(ptbr, vpn_q);
            end
            StRefill: begin
                tlb_wr     = 1'b1;
                tlb_vpn    = vpn_q;
                tlb_pte_in = pte_q;
            end
            default: ;
        endcase
        cp0_busy = cp0_pend_q;
        i_ack    = ack_q && (side_q == SideIf);
        d_ack    = ack_q && (side_q == SideMem);
        i_pte    = i_ack ? pte_q : '0;
        d_pte    = d_ack ? pte_q : '0;
        i_fault  = i_ack && fault_q;
        d_fault  = d_ack && fault_q;
    end

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
// Directed bench for tlb_walk_ctrl with a behavioural 8-entry TLB alongside.
module tb_tlb_walk_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        i_req, d_req, i_ack, d_ack, i_fault, d_fault;
    logic [19:0] i_vpn, d_vpn, cp0_vpn, tlb_vpn;
    logic [23:0] i_pte, d_pte, cp0_pte, tlb_pte_in, tlb_pte;
    logic        cp0_tlbwi, cp0_busy, tlb_wi, tlb_wr, tlb_hit, mem_req, mem_ack;
    logic [2:0]  cp0_index, tlb_index;
    logic [31:0] ptbr, mem_addr, mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tlb_walk_ctrl dut (
        .clk        (clk),
        .clrn       (clrn),
        .i_req      (i_req),
        .i_vpn      (i_vpn),
        .i_ack      (i_ack),
        .i_pte      (i_pte),
        .i_fault    (i_fault),
        .d_req      (d_req),
        .d_vpn      (d_vpn),
        .d_ack      (d_ack),
        .d_pte      (d_pte),
        .d_fault    (d_fault),
        .cp0_tlbwi  (cp0_tlbwi),
        .cp0_index  (cp0_index),
        .cp0_vpn    (cp0_vpn),
        .cp0_pte    (cp0_pte),
        .cp0_busy   (cp0_busy),
        .ptbr       (ptbr),
        .tlb_vpn    (tlb_vpn),
        .tlb_pte_in (tlb_pte_in),
        .tlb_wi     (tlb_wi),
        .tlb_wr     (tlb_wr),
        .tlb_index  (tlb_index),
        .tlb_hit    (tlb_hit),
        .tlb_pte    (tlb_pte),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural TLB: combinational CAM hit, registered PTE read, FIFO replacement for tlb_wr.
    logic [19:0] m_vpn [8];
    logic [23:0] m_pte [8];
    logic [7:0]  m_val  = '0;
    logic [2:0]  m_repl = '0;
    logic [23:0] hit_pte;

    always_comb begin
        tlb_hit = 1'b0;
        hit_pte = '0;
        for (int k = 0; k < 8; k++) begin
            if (m_val[k] && m_vpn[k] == tlb_vpn) begin
                tlb_hit = 1'b1;
                hit_pte = m_pte[k];
            end
        end
    end

    always @(posedge clk) begin
        tlb_pte <= hit_pte;
        if (tlb_wi) begin
            m_vpn[tlb_index] <= tlb_vpn;
            m_pte[tlb_index] <= tlb_pte_in;
            m_val[tlb_index] <= 1'b1;
        end
        if (tlb_wr) begin
            m_vpn[m_repl] <= tlb_vpn;
            m_pte[m_repl] <= tlb_pte_in;
            m_val[m_repl] <= 1'b1;
            m_repl        <= m_repl + 3'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int     n;
    int     nack;
    int     ack_tick [4];
    logic   ack_side [4];
    logic   ack_seen;

    initial begin
        clrn = 1'b0; i_req = 1'b0; d_req = 1'b0; i_vpn = '0; d_vpn = '0;
        cp0_tlbwi = 1'b0; cp0_index = '0; cp0_vpn = '0; cp0_pte = '0;
        ptbr = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(cp0_busy), 32'd0);
        check("rst_tlb", {tlb_wi, tlb_wr, 10'd0, tlb_vpn}, 32'd0);
        clrn = 1'b1;
        tick();

        // CP0 write, then a second pulse while pending must be dropped
        cp0_tlbwi = 1'b1; cp0_index = 3'd2; cp0_vpn = 20'h12345; cp0_pte = 24'h0A5A5B;
        tick();
        check("cp0_busy", 32'(cp0_busy), 32'd1);
        check("cp0_wi", 32'(tlb_wi), 32'd1);
        check("cp0_idx", 32'(tlb_index), 32'd2);
        check("cp0_vpn", 32'(tlb_vpn), 32'h12345);
        check("cp0_pte", 32'(tlb_pte_in), 32'h0A5A5B);
        cp0_vpn = 20'h11111; cp0_pte = 24'h000001;
        tick();
        check("cp0_drop_busy", 32'(cp0_busy), 32'd0);
        check("cp0_drop_wi", 32'(tlb_wi), 32'd0);
        cp0_tlbwi = 1'b0;

        // MEM hit, ack three cycles after request
        d_req = 1'b1; d_vpn = 20'h12345;
        tick();
        check("hit_lookup_vpn", 32'(tlb_vpn), 32'h12345);
        check("hit_no_ack1", 32'(d_ack), 32'd0);
        tick();
        check("hit_no_ack2", 32'(d_ack), 32'd0);
        check("hit_no_mem", 32'(mem_req), 32'd0);
        tick();
        check("hit_d_ack", 32'(d_ack), 32'd1);
        check("hit_d_pte", 32'(d_pte), 32'h0A5A5B);
        check("hit_d_fault", 32'(d_fault), 32'd0);
        check("hit_i_ack", 32'(i_ack), 32'd0);
        d_req = 1'b0;
        tick();

        // IF miss, walk and refill
        ptbr = 32'h8000_0000; i_req = 1'b1; i_vpn = 20'h00010;
        tick();
        tick();
        check("miss_mem_req", 32'(mem_req), 32'd1);
        check("miss_addr", mem_addr, 32'h8000_0040);
        tick();
        check("miss_wait_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h00AB_CDE1;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("refill_wr", 32'(tlb_wr), 32'd1);
        check("refill_wi", 32'(tlb_wi), 32'd0);
        check("refill_vpn", 32'(tlb_vpn), 32'h00010);
        check("refill_pte", 32'(tlb_pte_in), 32'hABCDE1);
        check("refill_mem_req", 32'(mem_req), 32'd0);
        tick();
        check("done_wr", 32'(tlb_wr), 32'd0);
        check("done_no_ack", 32'(i_ack), 32'd0);
        tick();
        check("miss_i_ack", 32'(i_ack), 32'd1);
        check("miss_i_pte", 32'(i_pte), 32'hABCDE1);
        check("miss_i_fault", 32'(i_fault), 32'd0);
        i_req = 1'b0;
        tick();

        // Same VPN again: now a hit, no memory traffic
        i_req = 1'b1;
        tick();
        check("rehit_no_mem1", 32'(mem_req), 32'd0);
        tick();
        check("rehit_no_mem2", 32'(mem_req), 32'd0);
        tick();
        check("rehit_i_ack", 32'(i_ack), 32'd1);
        check("rehit_i_pte", 32'(i_pte), 32'hABCDE1);
        i_req = 1'b0;
        tick();

        // Invalid PTE with address wrap: no refill, fault ack
        ptbr = 32'hFFFF_FFF0; d_req = 1'b1; d_vpn = 20'h00020;
        tick();
        tick();
        check("wrap_addr", mem_addr, 32'h0000_0070);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0FF0;
        tick();
        mem_ack = 1'b0;
        check("inv_no_wr", 32'(tlb_wr), 32'd0);
        check("inv_no_ack", 32'(d_ack), 32'd0);
        tick();
        check("inv_d_ack", 32'(d_ack), 32'd1);
        check("inv_d_fault", 32'(d_fault), 32'd1);
        d_req = 1'b0;
        tick();

        // Timeout with a CP0 write arriving mid-walk
        ptbr = 32'h8000_0000; i_req = 1'b1; i_vpn = 20'h00030;
        tick();
        tick();
        check("to_addr", mem_addr, 32'h8000_00C0);
        n = 0;
        while (mem_req && n < 400) begin
            n++;
            if (n == 10) begin
                cp0_tlbwi = 1'b1; cp0_index = 3'd5; cp0_vpn = 20'h0ABCD; cp0_pte = 24'h000777;
            end
            tick();
            cp0_tlbwi = 1'b0;
        end
        check("to_req_cycles", n, 32'd256);
        check("to_busy", 32'(cp0_busy), 32'd1);
        check("to_done_wi", 32'(tlb_wi), 32'd0);
        check("to_done_ack", 32'(i_ack), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
        tick();
        mem_ack = 1'b0;
        check("to_i_ack", 32'(i_ack), 32'd1);
        check("to_i_fault", 32'(i_fault), 32'd1);
        check("to_mem_low", 32'(mem_req), 32'd0);
        check("cp0_after_wi", 32'(tlb_wi), 32'd1);
        check("cp0_after_idx", 32'(tlb_index), 32'd5);
        check("cp0_after_vpn", 32'(tlb_vpn), 32'h0ABCD);
        i_req = 1'b0;
        tick();
        check("late_ack_ignored", 32'(mem_req), 32'd0);
        check("cp0_after_busy", 32'(cp0_busy), 32'd0);

        // Round-robin from reset with both sides requesting hits
        clrn = 1'b0;
        i_req = 1'b1; i_vpn = 20'h00010; d_req = 1'b1; d_vpn = 20'h12345;
        tick();
        check("rst2_busy", 32'(cp0_busy), 32'd0);
        check("rst2_ack", 32'({i_ack, d_ack}), 32'd0);
        clrn = 1'b1;
        nack = 0;
        for (int c = 1; c <= 60 && nack < 4; c++) begin
            tick();
            if (i_ack || d_ack) begin
                ack_side[nack] = d_ack;
                ack_tick[nack] = c;
                nack++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_count", nack, 32'd4);
        check("rr_first_lat", ack_tick[0], 32'd3);
        check("rr_g0", 32'(ack_side[0]), 32'd0);
        check("rr_g1", 32'(ack_side[1]), 32'd1);
        check("rr_g2", 32'(ack_side[2]), 32'd0);
        check("rr_g3", 32'(ack_side[3]), 32'd1);
        tick();

        // Reset in WALK_WAIT: outputs clear at once, no ack afterwards
        d_req = 1'b1; d_vpn = 20'h00040;
        tick();
        tick();
        check("rw_addr", mem_addr, 32'h8000_0100);
        tick();
        check("rw_wait_req", 32'(mem_req), 32'd1);
        #2 clrn = 1'b0;
        #1;
        check("rw_mem_low", 32'(mem_req), 32'd0);
        check("rw_addr_zero", mem_addr, 32'd0);
        check("rw_tlb_zero", {tlb_wi, tlb_wr, 10'd0, tlb_vpn}, 32'd0);
        d_req = 1'b0;
        tick();
        clrn = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            ack_seen = ack_seen | i_ack | d_ack | mem_req;
        end
        check("rw_no_ack", 32'(ack_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
